// File: rtl/actuated_phase_scheduler.sv
// Demand-actuated round-robin phase sequencer for a four-way intersection.
// Optional emergency preemption is built when EMERGENCY_PREEMPT_EN is defined.
module actuated_phase_scheduler #(
  parameter int MIN_GREEN    = 15,
  parameter int YELLOW_TIME  = 5,
  parameter int ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] car_req,
  input  logic [3:0] emerg_req,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] active_dir,
  output logic [5:0] countdown,
  output logic       grant_pulse
);

  if (MIN_GREEN < 1 || MIN_GREEN > 63) begin : g_bad_min_green
    $error("actuated_phase_scheduler: MIN_GREEN must be 1..63");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > 63) begin : g_bad_yellow_time
    $error("actuated_phase_scheduler: YELLOW_TIME must be 1..63");
  end
  if (ALL_RED_TIME < 1 || ALL_RED_TIME > 63) begin : g_bad_all_red_time
    $error("actuated_phase_scheduler: ALL_RED_TIME must be 1..63");
  end

  localparam logic [5:0] GREEN_LOAD  = 6'(MIN_GREEN);
  localparam logic [5:0] YELLOW_LOAD = 6'(YELLOW_TIME);
  localparam logic [5:0] ALL_RED_LOAD = 6'(ALL_RED_TIME);

  typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED} state_t;

  state_t     state, state_d;
  logic [1:0] dir_d, next_dir, next_dir_d, rr_dir, emerg_dir;
  logic [5:0] count_d;
  logic [3:0] pending, pending_d, others;
  logic       grant_d, emerg_hold, emerg_preempt;

  assign others = pending & ~(4'b0001 << active_dir);

  // Descending scan so the nearest pending approach after active_dir wins.
  always_comb begin
    rr_dir = active_dir;
    for (int i = 3; i >= 1; i--) begin
      if (others[active_dir + 2'(i)]) rr_dir = active_dir + 2'(i);
    end
  end

`ifdef EMERGENCY_PREEMPT_EN
  always_comb begin
    emerg_dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emerg_req[i]) emerg_dir = 2'(i);
    end
  end
  assign emerg_hold    = (|emerg_req) && (emerg_dir == active_dir);
  assign emerg_preempt = (|emerg_req) && (emerg_dir != active_dir);
`else
  logic unused_emerg;
  assign unused_emerg  = ^emerg_req;
  assign emerg_dir     = 2'd0;
  assign emerg_hold    = 1'b0;
  assign emerg_preempt = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    dir_d      = active_dir;
    count_d    = countdown;
    next_dir_d = next_dir;
    grant_d    = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    pending_d  = pending | car_req | emerg_req;
`else
    pending_d  = pending | car_req;
`endif
    case (state)
      GREEN: begin
        if (tick && !emerg_hold) begin
          if (emerg_preempt) begin
            state_d    = YELLOW;
            next_dir_d = emerg_dir;
            count_d    = YELLOW_LOAD;
          end else if (countdown != 6'd0) begin
            count_d = countdown - 6'd1;
          end else if (|others) begin
            state_d    = YELLOW;
            next_dir_d = rr_dir;
            count_d    = YELLOW_LOAD;
          end
        end
      end
      YELLOW: begin
        if (emerg_hold || emerg_preempt) next_dir_d = emerg_dir;
        if (tick) begin
          if (countdown != 6'd0) begin
            count_d = countdown - 6'd1;
          end else begin
            state_d = ALL_RED;
            count_d = ALL_RED_LOAD;
          end
        end
      end
      ALL_RED: begin
        if (emerg_hold || emerg_preempt) next_dir_d = emerg_dir;
        if (tick) begin
          if (countdown != 6'd0) begin
            count_d = countdown - 6'd1;
          end else begin
            state_d = GREEN;
            dir_d   = next_dir_d;
            count_d = GREEN_LOAD;
            grant_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = GREEN;
        count_d = GREEN_LOAD;
      end
    endcase
    // The served approach's request is consumed on entry and ignored while green.
    if (state_d == GREEN) pending_d[dir_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= GREEN;
      active_dir  <= 2'd0;
      countdown   <= GREEN_LOAD;
      pending     <= 4'b0000;
      next_dir    <= 2'd0;
      grant_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      active_dir  <= dir_d;
      countdown   <= count_d;
      pending     <= pending_d;
      next_dir    <= next_dir_d;
      grant_pulse <= grant_d;
    end
  end

  always_comb begin
    green  = 4'b0000;
    yellow = 4'b0000;
    red    = 4'b1111;
    case (state)
      GREEN: begin
        green[active_dir] = 1'b1;
        red[active_dir]   = 1'b0;
      end
      YELLOW: begin
        yellow[active_dir] = 1'b1;
        red[active_dir]    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
